// File: rtl/pc_seg_display.sv
// pc_seg_display: eight-digit multiplexed seven-segment driver.
// Captures a 32-bit word on a strobe and scans its hex nibbles onto a
// shared active-low segment bus, one digit every SCAN_DIV clocks, with
// optional leading-zero blanking. All outputs are registered.
module pc_seg_display #(
    parameter int unsigned SCAN_DIV      = 50000,
    parameter int unsigned LEADING_BLANK = 0
) (
    input  logic        clk,
    input  logic        rst,     // asynchronous, active-low
    input  logic        cs,
    input  logic [31:0] i_data,
    output logic [7:0]  o_seg,
    output logic [7:0]  o_sel
);

    // Prescaler width; a divide-by-1 still needs a one-bit counter.
    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(SCAN_DIV - 1);

    // Active-low hex font, dp off in bit 7.
    function automatic logic [7:0] hex_code(input logic [3:0] nib);
        logic [7:0] code;
        case (nib)
            4'h0:    code = 8'hC0;
            4'h1:    code = 8'hF9;
            4'h2:    code = 8'hA4;
            4'h3:    code = 8'hB0;
            4'h4:    code = 8'h99;
            4'h5:    code = 8'h92;
            4'h6:    code = 8'h82;
            4'h7:    code = 8'hF8;
            4'h8:    code = 8'h80;
            4'h9:    code = 8'h90;
            4'hA:    code = 8'h88;
            4'hB:    code = 8'h83;
            4'hC:    code = 8'hC6;
            4'hD:    code = 8'hA1;
            4'hE:    code = 8'h86;
            default: code = 8'h8E;
        endcase
        return code;
    endfunction

    logic [31:0]      disp_q,    disp_d;
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       idx_q,     idx_d;
    logic [7:0]       seg_q,     seg_d;
    logic [7:0]       sel_q,     sel_d;
    logic             tc;
    logic [3:0]       nibble;
    logic [7:0]       blank;

    assign tc = (div_cnt_q == TC_VAL);

    // Holding register, prescaler and digit index next-state.
    always_comb begin
        disp_d    = cs ? i_data : disp_q;
        div_cnt_d = tc ? '0 : div_cnt_q + CNT_W'(1);
        idx_d     = tc ? idx_q + 3'd1 : idx_q;
    end

    // Per-digit blank flags: digit k is dark when every nibble from k up is zero.
    always_comb begin
        logic seen;
        // NOTE: every combinational output gets a default before any branch or
        // loop writes it; a path that skips the assignment would infer a latch.
        // Blocking '=' is right here because 'seen' is meant to ripple through
        // the loop within the same evaluation.
        seen  = 1'b0;
        blank = '0;
        for (int k = 7; k >= 1; k--) begin
            seen     = seen | (|disp_q[4*k +: 4]);
            blank[k] = ~seen;
        end
    end

    // Next-output values for the digit currently indexed.
    always_comb begin
        nibble = disp_q[{idx_q, 2'b00} +: 4];
        sel_d  = ~(8'b1 << idx_q);
        if ((LEADING_BLANK != 0) && blank[idx_q]) begin
            seg_d = 8'hFF;
        end else begin
            seg_d = hex_code(nibble);
        end
    end

    // State and output registers; reset leaves the display dark at digit 0.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking '<=' so every register samples
        // pre-edge values; blocking here would make results depend on statement order.
        if (!rst) begin
            disp_q    <= '0;
            div_cnt_q <= '0;
            idx_q     <= '0;
            seg_q     <= 8'hFF;
            sel_q     <= 8'hFF;
        end else begin
            disp_q    <= disp_d;
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            sel_q     <= sel_d;
        end
    end

    assign o_seg = seg_q;
    assign o_sel = sel_q;

endmodule

// File: tb/tb_pc_seg_display.sv
// tb_pc_seg_display: directed bench for pc_seg_display. Three instances share
// the stimulus: SCAN_DIV=4 plain, SCAN_DIV=4 with leading blanking, and
// SCAN_DIV=1 plain. Expected segment codes are hand-written per digit.
module tb_pc_seg_display;

    logic        clk;
    logic        rst;
    logic        cs;
    logic [31:0] i_data;
    logic [7:0]  seg_dut, sel_dut;
    logic [7:0]  seg_blk, sel_blk;
    logic [7:0]  seg_fst, sel_fst;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_sel = 1'b0;
    bit chk_seg = 1'b0;

    // Expected digit codes 0..7 for the plain and the blanking instances.
    logic [7:0] tab_dut [8];
    logic [7:0] tab_blk [8];
    logic [7:0] hex_tab [16];

    pc_seg_display #(.SCAN_DIV(4), .LEADING_BLANK(0)) u_dut (
        .clk(clk), .rst(rst), .cs(cs), .i_data(i_data),
        .o_seg(seg_dut), .o_sel(sel_dut)
    );

    pc_seg_display #(.SCAN_DIV(4), .LEADING_BLANK(1)) u_blk (
        .clk(clk), .rst(rst), .cs(cs), .i_data(i_data),
        .o_seg(seg_blk), .o_sel(sel_blk)
    );

    pc_seg_display #(.SCAN_DIV(1), .LEADING_BLANK(0)) u_fst (
        .clk(clk), .rst(rst), .cs(cs), .i_data(i_data),
        .o_seg(seg_fst), .o_sel(sel_fst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @cyc%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // One clock: advance to the edge, then sample on the falling edge.
    task automatic tick();
        int d4;
        int d1;
        logic [7:0] e4;
        logic [7:0] e1;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        d4 = ((cyc - 1) / 4) % 8;
        d1 = (cyc - 1) % 8;
        e4 = 8'b1 << d4;
        e4 = ~e4;
        e1 = 8'b1 << d1;
        e1 = ~e1;
        if (chk_sel) begin
            check("sel_dut", sel_dut, e4);
            check("sel_blk", sel_blk, e4);
            check("sel_fst", sel_fst, e1);
        end
        if (chk_seg) begin
            check("seg_dut", seg_dut, tab_dut[d4]);
            check("seg_blk", seg_blk, tab_blk[d4]);
            check("seg_fst", seg_fst, tab_dut[d1]);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Present a word with cs for one edge; seg checks pause across the load edge.
    task automatic load_word(input logic [31:0] w);
        cs      = 1'b1;
        i_data  = w;
        chk_seg = 1'b0;
        tick();
        cs      = 1'b0;
    endtask

    task automatic check_all_seg(input string tag, input logic [7:0] exp);
        check({tag, "_dut"}, seg_dut, exp);
        check({tag, "_blk"}, seg_blk, exp);
        check({tag, "_fst"}, seg_fst, exp);
    endtask

    task automatic check_dark(input string tag);
        check({tag, "_seg_dut"}, seg_dut, 8'hFF);
        check({tag, "_sel_dut"}, sel_dut, 8'hFF);
        check({tag, "_seg_blk"}, seg_blk, 8'hFF);
        check({tag, "_sel_blk"}, sel_blk, 8'hFF);
        check({tag, "_seg_fst"}, seg_fst, 8'hFF);
        check({tag, "_sel_fst"}, sel_fst, 8'hFF);
    endtask

    initial begin
        hex_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        rst    = 1'b0;
        cs     = 1'b0;
        i_data = '0;

        // Reset held for three cycles: all dark.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_dark("reset");
        end

        // Release and capture 0x0040_0000 on the first edge; one full frame + 1.
        rst     = 1'b1;
        cyc     = 0;
        chk_sel = 1'b1;
        tab_dut = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h99, 8'hC0, 8'hC0};
        tab_blk = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h99, 8'hFF, 8'hFF};
        cs      = 1'b1;
        i_data  = 32'h0040_0000;
        chk_seg = 1'b1;
        tick();
        cs      = 1'b0;
        run(32);

        // Full hex map.
        load_word(32'h89AB_CDEF);
        tab_dut = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
        tab_blk = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
        chk_seg = 1'b1;
        run(32);

        // Leading blanking of 0x0000_0A30.
        load_word(32'h0000_0A30);
        tab_dut = '{8'hC0, 8'hB0, 8'h88, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        tab_blk = '{8'hC0, 8'hB0, 8'h88, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        chk_seg = 1'b1;
        run(32);

        // Value zero: blanking instance shows only digit 0.
        load_word(32'h0);
        tab_dut = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        tab_blk = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        chk_seg = 1'b1;
        run(32);

        // Move to the first cycle of a digit-0 dwell on the SCAN_DIV=4 units.
        for (int i = 0; i < 64; i++) begin
            if (((cyc - 1) % 4 == 0) && (((cyc - 1) / 4) % 8 == 0)) break;
            tick();
        end
        check("align_sel_dut", sel_dut, 8'hFE);

        // Capture mid-digit: C0 -> F9 two edges after the cs sample.
        cs      = 1'b1;
        i_data  = 32'h1;
        chk_seg = 1'b0;
        tick();
        cs      = 1'b0;
        check("cap_e1_dut", seg_dut, 8'hC0);
        tick();
        check("cap_e2_dut", seg_dut, 8'hF9);
        check("cap_e2_blk", seg_blk, 8'hF9);
        tick();
        check("cap_e3_dut", seg_dut, 8'hF9);
        tick();
        check("cap_d1_dut", seg_dut, 8'hC0);
        check("cap_d1_blk", seg_blk, 8'hFF);

        // cs held high: every digit follows a word of repeated nibbles.
        cs     = 1'b1;
        i_data = 32'h1111_1111;
        tick();
        for (int k = 2; k <= 6; k++) begin
            i_data = 32'h1111_1111 * k;
            tick();
            check_all_seg("track", hex_tab[k-1]);
        end

        // cs dropped: value freezes at 0x6666_6666.
        cs     = 1'b0;
        i_data = 32'h7777_7777;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all_seg("hold", 8'h82);
        end

        // Reach digit 6 on the SCAN_DIV=4 units, then reset between edges.
        for (int i = 0; i < 40; i++) begin
            if (((cyc - 1) / 4) % 8 == 6) break;
            tick();
        end
        check("pre_rst_sel_dut", sel_dut, 8'hBF);
        rst     = 1'b0;
        chk_sel = 1'b0;
        #1;
        check_dark("async_rst");
        @(negedge clk);
        check_dark("rst_hold");

        // Release: scan restarts at digit 0 with a full dwell, display cleared.
        rst     = 1'b1;
        cyc     = 0;
        chk_sel = 1'b1;
        tab_dut = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        tab_blk = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        chk_seg = 1'b1;
        run(9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
